// File: rtl/pong_game_if.sv
// Pong game interface bundle.
// Purpose : carries the pixel coordinates and player controls into the game
//           block and the pixel colour / score status back out.
// Signals : hcount, vcount        - current pixel x / line y (10 bit)
//           p1_up/dn, p2_up/dn    - paddle buttons, level, synchronous to clk
//           start                 - level, restarts the game from GAME_OVER
//           r, g, b               - registered pixel colour
//           score_p1, score_p2    - 4 bit scores
//           game_over             - high while the game has ended
// master = timing stage / control side, slave = the game block.
interface pong_game_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       p1_up;
  logic       p1_dn;
  logic       p2_up;
  logic       p2_dn;
  logic       start;
  logic       r;
  logic       g;
  logic       b;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;

  modport master (
    output hcount, vcount, p1_up, p1_dn, p2_up, p2_dn, start,
    input  r, g, b, score_p1, score_p2, game_over
  );

  modport slave (
    input  hcount, vcount, p1_up, p1_dn, p2_up, p2_dn, start,
    output r, g, b, score_p1, score_p2, game_over
  );
endinterface

// File: rtl/pong_game.sv
// Pong game core.
// Purpose : runs the game state (paddles, ball, bounces, scoring) once per
//           frame and renders one registered pixel colour per clock from the
//           incoming pixel coordinates. Colour lags hcount/vcount by one clk,
//           so the timing stage delays its syncs by one clk to match.
// Ports   : clk   - pixel clock
//           reset - asynchronous, active-low
//           bus   - pong_game_if.slave (coordinates, buttons, start in;
//                   r/g/b, scores, game_over out)
module pong_game #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int BALL_SIZE    = 8,
  parameter int P1_X         = 16,
  parameter int P2_X         = 616,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  pong_game_if.slave bus
);
  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  // 10 bit constants for register updates
  localparam logic [9:0] BX0    = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] BY0    = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] PY0    = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] PY_MAX = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] PSPD   = 10'(PADDLE_SPEED);
  localparam logic [9:0] SPD    = 10'(BALL_SPEED);
  localparam logic [9:0] L_STOP = 10'(P1_X + PADDLE_W);
  localparam logic [9:0] R_STOP = 10'(P2_X - BALL_SIZE);
  localparam logic [9:0] B_STOP = 10'(V_ACTIVE - BALL_SIZE);

  // 11 bit constants so sums like bx+size+speed cannot overflow in compares
  localparam logic [10:0] K_HA   = 11'(H_ACTIVE);
  localparam logic [10:0] K_VA   = 11'(V_ACTIVE);
  localparam logic [10:0] K_BS   = 11'(BALL_SIZE);
  localparam logic [10:0] K_SPD  = 11'(BALL_SPEED);
  localparam logic [10:0] K_PW   = 11'(PADDLE_W);
  localparam logic [10:0] K_PH   = 11'(PADDLE_H);
  localparam logic [10:0] K_P1X  = 11'(P1_X);
  localparam logic [10:0] K_P2X  = 11'(P2_X);
  localparam logic [10:0] K_LF   = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] K_NETL = 11'(H_ACTIVE / 2 - 2);
  localparam logic [10:0] K_NETR = 11'(H_ACTIVE / 2 + 1);

  typedef enum logic [1:0] {SERVE, PLAY, GAME_OVER} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [9:0]       bx_q, bx_d, by_q, by_d;
  logic             dx_q, dx_d, dy_q, dy_d;   // 1 = right / down
  logic [9:0]       p1y_q, p1y_d, p2y_q, p2y_d;
  logic [3:0]       score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [2:0]       rgb_q, rgb_d;

  logic [10:0] bx_e, by_e, p1y_e, p2y_e, hc_e, vc_e;
  logic        tick;
  logic        wall_t, wall_b, hit_l, hit_r, miss_l, miss_r;
  logic        in_ball, in_p1, in_p2, in_net;

  assign bx_e  = {1'b0, bx_q};
  assign by_e  = {1'b0, by_q};
  assign p1y_e = {1'b0, p1y_q};
  assign p2y_e = {1'b0, p2y_q};
  assign hc_e  = {1'b0, bus.hcount};
  assign vc_e  = {1'b0, bus.vcount};

  // First clock of vertical blanking: one game update per frame.
  assign tick = (bus.hcount == 10'd0) && (vc_e == K_VA);

  assign wall_t = !dy_q && (by_e < K_SPD);
  assign wall_b =  dy_q && (by_e + K_BS + K_SPD > K_VA);
  // Paddle faces catch the ball only in the one step that would cross them.
  assign hit_l  = !dx_q && (bx_e >= K_LF) && (bx_e < K_LF + K_SPD) &&
                  (by_e + K_BS > p1y_e) && (by_e < p1y_e + K_PH);
  assign hit_r  =  dx_q && (bx_e + K_BS <= K_P2X) && (bx_e + K_BS + K_SPD > K_P2X) &&
                  (by_e + K_BS > p2y_e) && (by_e < p2y_e + K_PH);
  assign miss_l = !dx_q && (bx_e < K_SPD);
  assign miss_r =  dx_q && (bx_e + K_BS + K_SPD > K_HA);

  function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up,
                                             input logic dn);
    if (up && !dn)      return (y < PSPD) ? 10'd0 : y - PSPD;
    else if (dn && !up) return (y > PY_MAX - PSPD) ? PY_MAX : y + PSPD;
    else                return y;
  endfunction

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    p1y_d       = p1y_q;
    p2y_d       = p2y_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;

    if (tick && state_q != GAME_OVER) begin
      p1y_d = paddle_next(p1y_q, bus.p1_up, bus.p1_dn);
      p2y_d = paddle_next(p2y_q, bus.p2_up, bus.p2_dn);
    end

    case (state_q)
      SERVE: begin
        if (tick) begin
          if (serve_cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            serve_cnt_d = '0;
            state_d     = PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (wall_t) begin
            by_d = 10'd0;
            dy_d = 1'b1;
          end else if (wall_b) begin
            by_d = B_STOP;
            dy_d = 1'b0;
          end else begin
            by_d = dy_q ? by_q + SPD : by_q - SPD;
          end

          if (hit_l) begin
            bx_d = L_STOP;
            dx_d = 1'b1;
          end else if (hit_r) begin
            bx_d = R_STOP;
            dx_d = 1'b0;
          end else if (miss_l) begin
            // Re-serve from centre heading toward the player who missed.
            score_p2_d = score_p2_q + 4'd1;
            bx_d       = BX0;
            by_d       = BY0;
            dx_d       = 1'b0;
            state_d    = (score_p2_q + 4'd1 == 4'(WIN_SCORE)) ? GAME_OVER : SERVE;
          end else if (miss_r) begin
            score_p1_d = score_p1_q + 4'd1;
            bx_d       = BX0;
            by_d       = BY0;
            dx_d       = 1'b1;
            state_d    = (score_p1_q + 4'd1 == 4'(WIN_SCORE)) ? GAME_OVER : SERVE;
          end else begin
            bx_d = dx_q ? bx_q + SPD : bx_q - SPD;
          end
        end
      end
      GAME_OVER: begin
        // start is honoured on any clock, not only on tick.
        if (bus.start) begin
          state_d     = SERVE;
          serve_cnt_d = '0;
          bx_d        = BX0;
          by_d        = BY0;
          dx_d        = 1'b1;
          dy_d        = 1'b1;
          p1y_d       = PY0;
          p2y_d       = PY0;
          score_p1_d  = 4'd0;
          score_p2_d  = 4'd0;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  // Rectangles are left/top inclusive, right/bottom exclusive.
  assign in_ball = (state_q != GAME_OVER) && (hc_e >= bx_e) && (hc_e < bx_e + K_BS) &&
                   (vc_e >= by_e) && (vc_e < by_e + K_BS);
  assign in_p1   = (hc_e >= K_P1X) && (hc_e < K_P1X + K_PW) &&
                   (vc_e >= p1y_e) && (vc_e < p1y_e + K_PH);
  assign in_p2   = (hc_e >= K_P2X) && (hc_e < K_P2X + K_PW) &&
                   (vc_e >= p2y_e) && (vc_e < p2y_e + K_PH);
  assign in_net  = (hc_e >= K_NETL) && (hc_e <= K_NETR) && !bus.vcount[4];

  always_comb begin
    rgb_d = 3'b000;
    if (hc_e < K_HA && vc_e < K_VA) begin
      if (in_ball)     rgb_d = 3'b111;
      else if (in_p1)  rgb_d = 3'b010;
      else if (in_p2)  rgb_d = 3'b001;
      else if (in_net) rgb_d = 3'b111;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SERVE;
      serve_cnt_q <= '0;
      bx_q        <= BX0;
      by_q        <= BY0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      p1y_q       <= PY0;
      p2y_q       <= PY0;
      score_p1_q  <= 4'd0;
      score_p2_q  <= 4'd0;
      rgb_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      p1y_q       <= p1y_d;
      p2y_q       <= p2y_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      rgb_q       <= rgb_d;
    end
  end

  assign bus.r         = rgb_q[2];
  assign bus.g         = rgb_q[1];
  assign bus.b         = rgb_q[0];
  assign bus.score_p1  = score_p1_q;
  assign bus.score_p2  = score_p2_q;
  assign bus.game_over = (state_q == GAME_OVER);
endmodule

// File: tb/tb_pong_game.sv
// Testbench for pong_game: drives coordinates directly (a tick is one clock
// at hcount=0, vcount=480) and probes single pixels to locate ball/paddles.
module tb_pong_game;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pong_game_if bus();

  pong_game dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string      name;
    logic [11:0] mask;
    logic [11:0] exp;
  } exp_t;

  // Compared word layout: {r,g,b, score_p1, score_p2, game_over}
  localparam logic [11:0] M_RGB  = 12'hE00;
  localparam logic [11:0] M_STAT = 12'h1FF;
  localparam logic [11:0] M_ALL  = 12'hFFF;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic probe_en = 1'b0;
  logic probe_q  = 1'b0;
  event ev_now;

  task automatic compare_front();
    exp_t        e;
    logic [11:0] act;
    act = {bus.r, bus.g, bus.b, bus.score_p1, bus.score_p2, bus.game_over};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output: got %h with no expected entry", act);
    end else begin
      e = sb.pop_front();
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got %h required %h (mask %h)", e.name, act & e.mask,
                 e.exp & e.mask, e.mask);
      end else begin
        $display("ok   %s: %h", e.name, act & e.mask);
      end
    end
  endtask

  // Monitor: registered outputs appear one clock after a probe is driven.
  always @(posedge clk) probe_q <= probe_en;
  always @(negedge clk) if (probe_q) compare_front();
  always @(ev_now) compare_front();

  task automatic idle();
    bus.hcount = 10'd1;
    bus.vcount = 10'd0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.hcount = 10'd0;
      bus.vcount = 10'd480;
      @(negedge clk);
      idle();
    end
  endtask

  task automatic probe(input string nm, input int h, input int v, input logic [2:0] rgb);
    sb.push_back('{name: nm, mask: M_RGB, exp: {rgb, 9'd0}});
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    probe_en   = 1'b1;
    @(negedge clk);
    probe_en   = 1'b0;
    idle();
  endtask

  task automatic status(input string nm, input int s1, input int s2, input logic go);
    sb.push_back('{name: nm, mask: M_STAT, exp: {3'b000, 4'(s1), 4'(s2), go}});
    idle();
    probe_en = 1'b1;
    @(negedge clk);
    probe_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.p1_up = 1'b0; bus.p1_dn = 1'b0;
    bus.p2_up = 1'b0; bus.p2_dn = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---- reset behaviour ----
    probe("ball_at_centre", 316, 236, 3'b111);
    bus.hcount = 10'd316;
    bus.vcount = 10'd236;
    #2 rst_n = 1'b0;
    #1;
    sb.push_back('{name: "async_reset_clears", mask: M_ALL, exp: 12'h000});
    -> ev_now;
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // ---- game 1, point 1: serve with paddle saturation ----
    bus.p1_up = 1'b1;
    bus.p2_dn = 1'b1;
    ticks(51);
    probe("p1_y4_top", 16, 4, 3'b010);
    probe("p1_y4_above", 16, 3, 3'b000);
    ticks(1);
    probe("p1_reaches_0", 16, 0, 3'b010);
    ticks(8);
    probe("p1_bottom_row", 16, 63, 3'b010);
    probe("p1_bottom_excl", 16, 64, 3'b000);
    probe("p1_right_col", 23, 0, 3'b010);
    probe("p1_right_excl", 24, 0, 3'b000);
    probe("p2_sat_top", 616, 416, 3'b001);
    probe("p2_sat_above", 616, 415, 3'b000);
    probe("p2_corner", 623, 479, 3'b001);
    probe("p2_right_excl", 624, 479, 3'b000);
    probe("ball_held_60", 316, 236, 3'b111);
    probe("offscreen_h640", 640, 0, 3'b000);
    probe("offscreen_v480", 5, 480, 3'b000);
    bus.p1_up = 1'b0;
    bus.p2_dn = 1'b0;

    // play: p2 back up to 208 over 52 ticks; p1 both buttons = hold
    bus.p2_up = 1'b1;
    bus.p1_up = 1'b1;
    bus.p1_dn = 1'b1;
    ticks(1);
    probe("first_move", 318, 238, 3'b111);
    probe("first_move_left", 317, 238, 3'b000);
    probe("centre_vacated", 316, 236, 3'b000);
    ticks(4);
    probe("p1_both_hold", 16, 0, 3'b010);
    bus.p1_up = 1'b0;
    bus.p1_dn = 1'b0;
    ticks(47);
    bus.p2_up = 1'b0;
    probe("p2_back_208", 616, 208, 3'b001);
    probe("p2_back_above", 616, 207, 3'b000);
    ticks(66);
    probe("bottom_m118", 552, 472, 3'b111);
    probe("bottom_m118_above", 552, 471, 3'b000);
    ticks(1);
    probe("bottom_hold_m119", 554, 472, 3'b111);
    ticks(1);
    probe("bottom_up_m120", 556, 470, 3'b111);
    probe("bottom_up_above", 556, 469, 3'b000);
    ticks(38);
    probe("before_right_miss", 632, 394, 3'b111);
    status("no_score_yet", 0, 0, 1'b0);
    ticks(1);
    status("right_miss_p1", 1, 0, 1'b0);
    probe("reserve_centre", 316, 236, 3'b111);

    // points 2..9: right paddle at 208 never meets the ball
    for (int p = 2; p <= 9; p++) begin
      ticks(219);
      status($sformatf("score_p1_%0d", p), p, 0, (p == 9));
    end
    probe("ball_hidden", 316, 236, 3'b000);
    bus.p1_dn = 1'b1;
    ticks(5);
    bus.p1_dn = 1'b0;
    probe("paddle_frozen", 16, 0, 3'b010);
    status("score_no_wrap", 9, 0, 1'b1);

    // ---- restart ----
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    status("restart_cleared", 0, 0, 1'b0);
    probe("restart_ball", 316, 236, 3'b111);
    probe("restart_p1", 16, 208, 3'b010);
    probe("restart_p1_above", 16, 207, 3'b000);

    // ---- game 2, point 1: right paddle hit, top wall, left miss ----
    bus.p2_dn = 1'b1;
    ticks(60);
    bus.p2_dn = 1'b0;
    ticks(146);
    probe("pre_right_hit", 608, 418, 3'b111);
    ticks(1);
    probe("right_hit_pos", 608, 416, 3'b111);
    probe("right_hit_left", 607, 416, 3'b000);
    ticks(1);
    probe("after_right_hit", 606, 414, 3'b111);
    probe("after_right_edge", 605, 414, 3'b000);
    ticks(206);
    probe("top_by2", 194, 2, 3'b111);
    probe("top_by2_above", 194, 1, 3'b000);
    ticks(1);
    probe("top_by0", 192, 0, 3'b111);
    ticks(1);
    probe("top_hold_0", 190, 0, 3'b111);
    probe("top_hold_edge", 189, 0, 3'b000);
    ticks(1);
    probe("top_down_2", 188, 2, 3'b111);
    probe("top_down_above", 188, 1, 3'b000);
    ticks(93);
    probe("pass_paddle_bx2", 2, 188, 3'b111);
    probe("pass_paddle_edge", 1, 188, 3'b000);
    status("no_left_score", 0, 0, 1'b0);
    ticks(1);
    probe("bx0", 0, 190, 3'b111);
    ticks(1);
    status("left_miss_p2", 0, 1, 1'b0);
    probe("left_reserve", 316, 236, 3'b111);

    // ---- game 2, point 2: serve toward p1, left paddle hit ----
    bus.p1_dn = 1'b1;
    ticks(60);
    bus.p1_dn = 1'b0;
    probe("p1_sat_bottom", 16, 416, 3'b010);
    probe("p1_sat_above", 16, 415, 3'b000);
    ticks(146);
    probe("pre_left_hit", 24, 418, 3'b111);
    ticks(1);
    probe("left_hit_pos", 24, 416, 3'b111);
    probe("left_hit_paddle", 23, 416, 3'b010);
    ticks(1);
    probe("after_left_hit", 26, 414, 3'b111);
    probe("after_left_edge", 25, 414, 3'b000);
    status("final_scores", 0, 1, 1'b0);

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
